huffman_encoder: RTL

Serial Huffman encoder producing the bitstream consumed by `huffman_decoder`. It accepts one 3-bit symbol code (A–F) per handshake and emits the symbol's prefix codeword one bit per clock on `x`, MSB first. It sits upstream of the decoder: `x` drives the decoder's `x` input directly. Back-to-back symbols stream with no idle bit between codewords.

---
 rtl/huffman_encoder.sv | 80 ++++++++
 1 files changed

// File: rtl/huffman_encoder.sv
// Serial prefix-code encoder: one 3-bit symbol per handshake in, one code bit per clock out, MSB first.
// First bit appears the cycle after accept; sym_ready is held low until the current codeword's last bit.
module huffman_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sym,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       x,
  output logic       x_valid,
  output logic       err
);

  logic [3:0] sh_q, sh_d;
  logic [2:0] cnt_q, cnt_d;
  logic       x_q, x_d;
  logic       x_valid_q, x_valid_d;
  logic       err_q, err_d;
  logic       accept;

  // Ready during the last bit lets the next codeword follow with no gap.
  assign sym_ready = (cnt_q == 3'd0) || (cnt_q == 3'd1);
  assign accept    = sym_valid && sym_ready;

  always_comb begin
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    x_valid_d = x_valid_q;
    err_d     = 1'b0;
    if (accept) begin
      x_valid_d = 1'b1;
      // sh_d holds the bits after the first one, left-aligned.
      case (sym)
        3'b001:  begin x_d = 1'b0; cnt_d = 3'd1; sh_d = 4'b0000; end
        3'b010:  begin x_d = 1'b1; cnt_d = 3'd3; sh_d = 4'b0100; end
        3'b011:  begin x_d = 1'b1; cnt_d = 3'd3; sh_d = 4'b0000; end
        3'b100:  begin x_d = 1'b1; cnt_d = 3'd3; sh_d = 4'b1100; end
        3'b101:  begin x_d = 1'b1; cnt_d = 3'd4; sh_d = 4'b1010; end
        3'b110:  begin x_d = 1'b1; cnt_d = 3'd4; sh_d = 4'b1000; end
        default: begin
          x_d       = 1'b0;
          x_valid_d = 1'b0;
          cnt_d     = 3'd0;
          sh_d      = 4'b0000;
          err_d     = 1'b1;
        end
      endcase
    end else if (cnt_q > 3'd1) begin
      x_d   = sh_q[3];
      sh_d  = {sh_q[2:0], 1'b0};
      cnt_d = cnt_q - 3'd1;
    end else if (cnt_q == 3'd1) begin
      x_d       = 1'b0;
      x_valid_d = 1'b0;
      cnt_d     = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q      <= 4'b0000;
      cnt_q     <= 3'd0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      err_q     <= err_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign err     = err_q;

endmodule
